// File: rtl/random_ca_parity_gen_if.sv
// Stream/control bundle for random_ca_parity_gen. The generator drives it
// through the master modport; the consumer drives it through the slave modport.
interface random_ca_parity_gen_if #(
  parameter int Width   = 32,
  parameter int CAWidth = 64
);
  logic               ce;
  logic               seed_load;
  logic [CAWidth-1:0] seed;
  logic               ready;
  logic               valid;
  logic [Width-1:0]   random;
  logic               warm;

  modport master (
    input  ce, seed_load, seed, ready,
    output valid, random, warm
  );

  modport slave (
    output ce, seed_load, seed, ready,
    input  valid, random, warm
  );
endinterface

// File: rtl/random_ca_parity_gen.sv
// Cellular-automaton random word generator: ring of radius-1 cells, rotating
// rule schedule, warm-up phase and a valid/ready output register.
module random_ca_parity_gen #(
  parameter int                     Width      = 32,
  parameter int                     ParitWidth = 2,
  parameter int                     CAWidth    = Width * ParitWidth,
  parameter int                     RuleCount  = 4,
  parameter logic [RuleCount*8-1:0] RuleTable  = {8'd150, 8'd90, 8'd60, 8'd30},
  parameter int                     RuleHold   = 2,
  parameter int                     WarmUp     = 16,
  parameter logic [CAWidth-1:0]     Seed       = {CAWidth/4{4'b0101}}
) (
  input logic                    clk,
  input logic                    rst,
  random_ca_parity_gen_if.master bus
);

  localparam int HW = (RuleHold > 1) ? $clog2(RuleHold) : 1;
  localparam int RW = (RuleCount > 1) ? $clog2(RuleCount) : 1;
  localparam int WW = (WarmUp > 0) ? $clog2(WarmUp + 1) : 1;
  localparam logic [HW-1:0] HoldLast = HW'(RuleHold - 1);
  localparam logic [RW-1:0] RidxLast = RW'(RuleCount - 1);
  localparam logic [WW-1:0] WarmLast = WW'((WarmUp > 0) ? (WarmUp - 1) : 0);

  typedef enum logic {WARMUP = 1'b0, RUN = 1'b1} state_t;
  localparam state_t StartState = (WarmUp == 0) ? RUN : WARMUP;

  function automatic logic [CAWidth-1:0] ca_step(input logic [CAWidth-1:0] s,
                                                 input logic [7:0]         rule);
    logic [CAWidth-1:0] n;
    n = {CAWidth{1'b0}};
    for (int i = 0; i < CAWidth; i++) begin
      n[i] = rule[{s[(i + 1) % CAWidth], s[i], s[(i + CAWidth - 1) % CAWidth]}];
    end
    return n;
  endfunction

  // Even output bits are inverted so an all-zero parity group never yields a zero word.
  function automatic logic [Width-1:0] fold(input logic [CAWidth-1:0] s);
    logic [Width-1:0] w;
    w = {Width{1'b0}};
    for (int i = 0; i < Width; i++) begin
      w[i] = ((i % 2) == 1) ? (^s[i*ParitWidth +: ParitWidth])
                            : ~(^s[i*ParitWidth +: ParitWidth]);
    end
    return w;
  endfunction

  state_t             state_r, state_nxt_s;
  logic [CAWidth-1:0] ca_r, ca_nxt_s, ca_step_s;
  logic [RW-1:0]      ridx_r, ridx_nxt_s, ridx_step_s;
  logic [HW-1:0]      hold_r, hold_nxt_s, hold_step_s;
  logic [WW-1:0]      wcnt_r, wcnt_nxt_s;
  logic               valid_r, valid_nxt_s;
  logic [Width-1:0]   random_r, random_nxt_s;
  logic [7:0]         rule_s;

  assign rule_s    = RuleTable[32'(ridx_r) * 32'd8 +: 8];
  assign ca_step_s = ca_step(ca_r, rule_s);

  // Rule schedule position after one CA step
  always_comb begin
    hold_step_s = hold_r;
    ridx_step_s = ridx_r;
    if (hold_r == HoldLast) begin
      hold_step_s = {HW{1'b0}};
      if (ridx_r == RidxLast) begin
        ridx_step_s = {RW{1'b0}};
      end else begin
        ridx_step_s = ridx_r + 1'b1;
      end
    end else begin
      hold_step_s = hold_r + 1'b1;
    end
  end

  // Next-state and output-register logic; seed_load overrides everything
  always_comb begin
    state_nxt_s  = state_r;
    ca_nxt_s     = ca_r;
    ridx_nxt_s   = ridx_r;
    hold_nxt_s   = hold_r;
    wcnt_nxt_s   = wcnt_r;
    valid_nxt_s  = valid_r;
    random_nxt_s = random_r;
    if (bus.seed_load) begin
      ca_nxt_s     = (bus.seed == {CAWidth{1'b0}}) ? Seed : bus.seed;
      ridx_nxt_s   = {RW{1'b0}};
      hold_nxt_s   = {HW{1'b0}};
      wcnt_nxt_s   = {WW{1'b0}};
      valid_nxt_s  = 1'b0;
      random_nxt_s = {Width{1'b0}};
      state_nxt_s  = StartState;
    end else begin
      case (state_r)
        WARMUP: begin
          if (bus.ce) begin
            ca_nxt_s   = ca_step_s;
            ridx_nxt_s = ridx_step_s;
            hold_nxt_s = hold_step_s;
            wcnt_nxt_s = wcnt_r + 1'b1;
            state_nxt_s = (wcnt_r == WarmLast) ? RUN : WARMUP;
          end else begin
            state_nxt_s = WARMUP;
          end
        end
        RUN: begin
          if (!valid_r || bus.ready) begin
            if (bus.ce) begin
              random_nxt_s = fold(ca_r);
              valid_nxt_s  = 1'b1;
              ca_nxt_s     = ca_step_s;
              ridx_nxt_s   = ridx_step_s;
              hold_nxt_s   = hold_step_s;
            end else begin
              valid_nxt_s = 1'b0;
            end
          end else begin
            valid_nxt_s = valid_r;
          end
        end
        default: begin
          state_nxt_s = StartState;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= StartState;
      ca_r     <= Seed;
      ridx_r   <= {RW{1'b0}};
      hold_r   <= {HW{1'b0}};
      wcnt_r   <= {WW{1'b0}};
      valid_r  <= 1'b0;
      random_r <= {Width{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      ca_r     <= ca_nxt_s;
      ridx_r   <= ridx_nxt_s;
      hold_r   <= hold_nxt_s;
      wcnt_r   <= wcnt_nxt_s;
      valid_r  <= valid_nxt_s;
      random_r <= random_nxt_s;
    end
  end

  assign bus.valid  = valid_r;
  assign bus.random = random_r;
  assign bus.warm   = (state_r == WARMUP);

endmodule

// File: tb/tb_random_ca_parity_gen.sv
// Directed bench: a small instance (4-bit words, no warm-up) for the stream
// behaviour and a default instance for the warm-up latency.
module tb_random_ca_parity_gen;
  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  random_ca_parity_gen_if #(.Width(4),  .CAWidth(8))  bs ();
  random_ca_parity_gen_if #(.Width(32), .CAWidth(64)) bd ();

  random_ca_parity_gen #(
    .Width(4), .ParitWidth(2), .RuleHold(2), .WarmUp(0)
  ) dut_s (.clk(clk), .rst(rst), .bus(bs));

  random_ca_parity_gen dut_d (.clk(clk), .rst(rst), .bus(bd));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_step(input logic [63:0] m, input logic [7:0] r);
    logic [63:0] n;
    n = 64'd0;
    for (int i = 0; i < 64; i++) begin
      n[i] = r[{m[(i + 1) % 64], m[i], m[(i + 63) % 64]}];
    end
    return n;
  endfunction

  function automatic logic [31:0] ref_fold(input logic [63:0] m);
    logic [31:0] w;
    logic        p;
    w = 32'd0;
    for (int i = 0; i < 32; i++) begin
      p = m[2*i] ^ m[2*i+1];
      w[i] = ((i % 2) == 1) ? p : ~p;
    end
    return w;
  endfunction

  initial begin
    logic [7:0]  rules [4];
    logic [63:0] model;
    rules = '{8'd30, 8'd60, 8'd90, 8'd150};

    rst = 1'b1;
    bs.ce = 1'b0; bs.seed_load = 1'b0; bs.seed = 8'h00; bs.ready = 1'b0;
    bd.ce = 1'b0; bd.seed_load = 1'b0; bd.seed = 64'd0; bd.ready = 1'b0;
    #2;
    check("rst_valid_s",  {63'd0, bs.valid}, 64'd0);
    check("rst_random_s", {60'd0, bs.random}, 64'd0);
    check("rst_warm_s",   {63'd0, bs.warm}, 64'd0);
    check("rst_warm_d",   {63'd0, bd.warm}, 64'd1);
    check("rst_valid_d",  {63'd0, bd.valid}, 64'd0);
    tick();
    rst = 1'b0;

    // Seeded sequence 8'h01: words 4, D (state 83), E (state 46), A (rule 60 -> 65)
    bs.seed_load = 1'b1; bs.seed = 8'h01;
    tick();
    bs.seed_load = 1'b0;
    check("seed_valid0", {63'd0, bs.valid}, 64'd0);
    bs.ce = 1'b1; bs.ready = 1'b1;
    tick();
    check("seq_w0",       {60'd0, bs.random}, 64'h4);
    check("seq_w0_valid", {63'd0, bs.valid}, 64'd1);
    tick(); check("seq_w1", {60'd0, bs.random}, 64'hD);
    tick(); check("seq_w2", {60'd0, bs.random}, 64'hE);
    tick(); check("seq_w3", {60'd0, bs.random}, 64'hA);

    // Reseed during a transfer: word discarded, schedule restarts at rule 30
    bs.seed_load = 1'b1; bs.seed = 8'h01;
    tick();
    bs.seed_load = 1'b0;
    check("reseed_valid",  {63'd0, bs.valid}, 64'd0);
    check("reseed_random", {60'd0, bs.random}, 64'd0);
    tick(); check("reseed_w0", {60'd0, bs.random}, 64'h4);
    tick(); check("reseed_w1", {60'd0, bs.random}, 64'hD);

    // Back-pressure after the first word
    bs.ce = 1'b0; bs.seed_load = 1'b1; bs.seed = 8'h01;
    tick();
    bs.seed_load = 1'b0; bs.ce = 1'b1; bs.ready = 1'b0;
    tick();
    check("bp_w0", {60'd0, bs.random}, 64'h4);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_hold_random", {60'd0, bs.random}, 64'h4);
      check("bp_hold_valid",  {63'd0, bs.valid}, 64'd1);
    end
    bs.ready = 1'b1;
    tick(); check("bp_w1", {60'd0, bs.random}, 64'hD);
    tick(); check("bp_w2", {60'd0, bs.random}, 64'hE);

    // ce gating: word consumed, nothing new, then sequence resumes
    bs.ce = 1'b0;
    tick();
    check("ce0_valid",  {63'd0, bs.valid}, 64'd0);
    check("ce0_random", {60'd0, bs.random}, 64'hE);
    tick();
    check("ce0_valid2", {63'd0, bs.valid}, 64'd0);
    bs.ce = 1'b1;
    tick();
    check("ce1_w",     {60'd0, bs.random}, 64'hA);
    check("ce1_valid", {63'd0, bs.valid}, 64'd1);

    // Zero seed falls back to 8'h55, folding to 4'hA (and 55 is a rule-30 fixed point)
    bs.ce = 1'b0; bs.seed_load = 1'b1; bs.seed = 8'h00;
    tick();
    bs.seed_load = 1'b0;
    check("zero_valid0", {63'd0, bs.valid}, 64'd0);
    bs.ce = 1'b1;
    tick();
    check("zero_w0",    {60'd0, bs.random}, 64'hA);
    check("zero_valid", {63'd0, bs.valid}, 64'd1);
    tick();
    check("zero_w1", {60'd0, bs.random}, 64'hA);
    tick();
    check("zero_w2", {60'd0, bs.random}, 64'hA);
    tick();
    check("zero_w3", {60'd0, bs.random}, 64'h5);

    // Asynchronous reset mid-word, checked between clock edges
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid",  {63'd0, bs.valid}, 64'd0);
    check("arst_random", {60'd0, bs.random}, 64'd0);
    bd.ce = 1'b1; bd.ready = 1'b1;
    tick();
    rst = 1'b0;

    // Warm-up on the default instance: 16 discarded steps, then a word
    model = {16{4'b0101}};
    for (int k = 0; k < 16; k++) begin
      check("warm_high",   {63'd0, bd.warm}, 64'd1);
      check("warm_novalid", {63'd0, bd.valid}, 64'd0);
      model = ref_step(model, rules[(k / 2) % 4]);
      tick();
    end
    check("warm_done",    {63'd0, bd.warm}, 64'd0);
    check("warm_valid16", {63'd0, bd.valid}, 64'd0);
    tick();
    check("warm_first_valid", {63'd0, bd.valid}, 64'd1);
    check("warm_first_word",  {32'd0, bd.random}, {32'd0, ref_fold(model)});
    model = ref_step(model, rules[0]);
    tick();
    check("warm_second_word", {32'd0, bd.random}, {32'd0, ref_fold(model)});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
